// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// In-order store buffer (memory order buffer) for the LSU.
// - Dispatch allocates one entry per store at the tail.
// - The LSU writeback fills in the address and data of an entry and marks it
//   resolved.
// - ROB commit advances the commit pointer.
// - Committed, resolved entries drain to data memory from the head, in
//   program order.
// - Loads query the buffer combinationally for store-to-load forwarding.
// - A mispredict discards every uncommitted entry.
//
// Ports
//   clk_i, reset_n_i          clock (rising edge), async active-low reset
//   alloc_v_i                 allocate one store entry
//   alloc_ready_o             buffer not full
//   alloc_sb_num_o            current tail index
//   lsu_sb_v_i/_dest_i        store writeback valid / target entry
//   lsu_sb_addr_i/_data_i     resolved store address / data
//   ld_bypass_addr_i          load address under query
//   ld_bypass_sb_num_i        tail index captured when the load dispatched
//   ld_bypass_valid_o/_value_o forwarding hit / forwarded data
//   commit_v_i                retire the oldest uncommitted store
//   mispredict_i              flush all uncommitted entries
//   mem_wr_v_o/_addr_o/_data_o memory write request
//   mem_wr_ready_i            memory accepts the write this cycle
//   sb_count_o                occupancy (tail - head)
// -----------------------------------------------------------------------------
module store_buffer #(
   parameter int WORD_SIZE_P = 16,
   parameter int SB_ENTRY    = 8,
   localparam int IDX_W      = $clog2(SB_ENTRY),
   localparam int PTR_W      = IDX_W + 1
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   alloc_v_i,
   output logic                   alloc_ready_o,
   output logic [IDX_W-1:0]       alloc_sb_num_o,
   input  logic                   lsu_sb_v_i,
   input  logic [IDX_W-1:0]       lsu_sb_dest_i,
   input  logic [WORD_SIZE_P-1:0] lsu_sb_addr_i,
   input  logic [WORD_SIZE_P-1:0] lsu_sb_data_i,
   input  logic [WORD_SIZE_P-1:0] ld_bypass_addr_i,
   input  logic [IDX_W-1:0]       ld_bypass_sb_num_i,
   output logic                   ld_bypass_valid_o,
   output logic [WORD_SIZE_P-1:0] ld_bypass_value_o,
   input  logic                   commit_v_i,
   input  logic                   mispredict_i,
   output logic                   mem_wr_v_o,
   output logic [WORD_SIZE_P-1:0] mem_wr_addr_o,
   output logic [WORD_SIZE_P-1:0] mem_wr_data_o,
   input  logic                   mem_wr_ready_i,
   output logic [PTR_W-1:0]       sb_count_o
);

   localparam logic [PTR_W-1:0]       PTR_ZERO  = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]       PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]       PTR_FULL  = PTR_W'(SB_ENTRY);
   localparam logic [WORD_SIZE_P-1:0] WORD_ZERO = {WORD_SIZE_P{1'b0}};

   // Pointers carry one extra wrap bit so that full and empty can be told apart.
   logic [PTR_W-1:0]       head_r;
   logic [PTR_W-1:0]       cmt_r;
   logic [PTR_W-1:0]       tail_r;
   logic [SB_ENTRY-1:0]    resolved_r;
   logic [WORD_SIZE_P-1:0] addr_r [SB_ENTRY];
   logic [WORD_SIZE_P-1:0] data_r [SB_ENTRY];

   logic [IDX_W-1:0]       head_idx_s;
   logic [IDX_W-1:0]       tail_idx_s;
   logic [PTR_W-1:0]       count_s;
   logic                   full_s;
   logic                   alloc_fire_s;
   logic                   wb_fire_s;
   logic                   commit_fire_s;
   logic                   drain_v_s;
   logic                   drain_fire_s;
   logic [PTR_W-1:0]       cmt_nxt_s;
   logic [PTR_W-1:0]       tail_nxt_s;
   logic [IDX_W-1:0]       byp_len_s;
   logic                   byp_valid_s;
   logic [WORD_SIZE_P-1:0] byp_value_s;

   assign head_idx_s = head_r[IDX_W-1:0];
   assign tail_idx_s = tail_r[IDX_W-1:0];
   assign count_s    = tail_r - head_r;
   // Fullness is taken from registered state only.
   // A drain in the same cycle does not free a slot for an alloc in that cycle.
   assign full_s     = (count_s == PTR_FULL);

   // A mispredict squashes any same-cycle alloc or writeback.
   assign alloc_fire_s  = alloc_v_i && !full_s && !mispredict_i;
   assign wb_fire_s     = lsu_sb_v_i && !mispredict_i;
   assign commit_fire_s = commit_v_i && (cmt_r != tail_r);
   assign drain_v_s     = (head_r != cmt_r) && resolved_r[head_idx_s];
   assign drain_fire_s  = drain_v_s && mem_wr_ready_i;

   // Next commit pointer, and next tail including the mispredict rollback.
   always_comb begin
      cmt_nxt_s  = cmt_r;
      tail_nxt_s = tail_r;
      if (commit_fire_s) begin
         cmt_nxt_s = cmt_r + PTR_ONE;
      end else begin
         cmt_nxt_s = cmt_r;
      end
      if (mispredict_i) begin
         tail_nxt_s = cmt_nxt_s;
      end else if (alloc_fire_s) begin
         tail_nxt_s = tail_r + PTR_ONE;
      end else begin
         tail_nxt_s = tail_r;
      end
   end

   // Pointer state: head advances on each accepted memory write.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         head_r <= PTR_ZERO;
         cmt_r  <= PTR_ZERO;
         tail_r <= PTR_ZERO;
      end else begin
         head_r <= drain_fire_s ? (head_r + PTR_ONE) : head_r;
         cmt_r  <= cmt_nxt_s;
         tail_r <= tail_nxt_s;
      end
   end

   // Entry storage: alloc clears resolved, writeback fills the entry and sets it.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         resolved_r <= {SB_ENTRY{1'b0}};
         for (int i = 0; i < SB_ENTRY; i++) begin
            addr_r[i] <= WORD_ZERO;
            data_r[i] <= WORD_ZERO;
         end
      end else begin
         for (int i = 0; i < SB_ENTRY; i++) begin
            if (wb_fire_s && (lsu_sb_dest_i == IDX_W'(i))) begin
               resolved_r[i] <= 1'b1;
               addr_r[i]     <= lsu_sb_addr_i;
               data_r[i]     <= lsu_sb_data_i;
            end else if (alloc_fire_s && (tail_idx_s == IDX_W'(i))) begin
               resolved_r[i] <= 1'b0;
            end
         end
      end
   end

   // The search window holds the stores older than the load.
   // The window wraps modulo SB_ENTRY and is empty when sb_num equals head.
   assign byp_len_s = ld_bypass_sb_num_i - head_idx_s;

   // Forwarding search: scan from oldest to youngest, so the last hit wins.
   always_comb begin
      byp_valid_s = 1'b0;
      byp_value_s = WORD_ZERO;
      for (int i = 0; i < SB_ENTRY; i++) begin
         if ((IDX_W'(i) < byp_len_s) &&
             resolved_r[head_idx_s + IDX_W'(i)] &&
             (addr_r[head_idx_s + IDX_W'(i)] == ld_bypass_addr_i)) begin
            byp_valid_s = 1'b1;
            byp_value_s = data_r[head_idx_s + IDX_W'(i)];
         end else begin
            byp_valid_s = byp_valid_s;
            byp_value_s = byp_value_s;
         end
      end
   end

   assign alloc_ready_o     = !full_s;
   assign alloc_sb_num_o    = tail_idx_s;
   assign sb_count_o        = count_s;
   assign ld_bypass_valid_o = byp_valid_s;
   assign ld_bypass_value_o = byp_value_s;
   assign mem_wr_v_o        = drain_v_s;
   // Address and data read as zero whenever no write is being requested.
   assign mem_wr_addr_o     = drain_v_s ? addr_r[head_idx_s] : WORD_ZERO;
   assign mem_wr_data_o     = drain_v_s ? data_r[head_idx_s] : WORD_ZERO;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Self-checking bench for store_buffer.
// - Each test task drives stimulus and compares outputs directly.
// - Expected memory writes are queued when the commit is driven.
// - A negedge monitor pops and compares each accepted memory write.
// -----------------------------------------------------------------------------
module tb_store_buffer;

   localparam int W   = 16;
   localparam int N   = 8;
   localparam int IW  = 3;

   logic          clk_i;
   logic          reset_n_i;
   logic          alloc_v_i;
   logic          alloc_ready_o;
   logic [IW-1:0] alloc_sb_num_o;
   logic          lsu_sb_v_i;
   logic [IW-1:0] lsu_sb_dest_i;
   logic [W-1:0]  lsu_sb_addr_i;
   logic [W-1:0]  lsu_sb_data_i;
   logic [W-1:0]  ld_bypass_addr_i;
   logic [IW-1:0] ld_bypass_sb_num_i;
   logic          ld_bypass_valid_o;
   logic [W-1:0]  ld_bypass_value_o;
   logic          commit_v_i;
   logic          mispredict_i;
   logic          mem_wr_v_o;
   logic [W-1:0]  mem_wr_addr_o;
   logic [W-1:0]  mem_wr_data_o;
   logic          mem_wr_ready_i;
   logic [IW:0]   sb_count_o;

   int total;
   int bad;
   logic [31:0] exp_q[$];

   store_buffer #(.WORD_SIZE_P(W), .SB_ENTRY(N)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .alloc_v_i(alloc_v_i), .alloc_ready_o(alloc_ready_o), .alloc_sb_num_o(alloc_sb_num_o),
      .lsu_sb_v_i(lsu_sb_v_i), .lsu_sb_dest_i(lsu_sb_dest_i),
      .lsu_sb_addr_i(lsu_sb_addr_i), .lsu_sb_data_i(lsu_sb_data_i),
      .ld_bypass_addr_i(ld_bypass_addr_i), .ld_bypass_sb_num_i(ld_bypass_sb_num_i),
      .ld_bypass_valid_o(ld_bypass_valid_o), .ld_bypass_value_o(ld_bypass_value_o),
      .commit_v_i(commit_v_i), .mispredict_i(mispredict_i),
      .mem_wr_v_o(mem_wr_v_o), .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
      .mem_wr_ready_i(mem_wr_ready_i), .sb_count_o(sb_count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Scoreboard: each accepted write must match the oldest expected write.
   always @(negedge clk_i) begin : mon
      logic [31:0] e;
      if (reset_n_i && mem_wr_v_o && mem_wr_ready_i) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write got addr=%h data=%h, none expected", mem_wr_addr_o, mem_wr_data_o);
         end else begin
            e = exp_q.pop_front();
            if ({mem_wr_addr_o, mem_wr_data_o} !== e) begin
               bad++;
               $display("FAIL mem_write got addr=%h data=%h exp addr=%h data=%h",
                        mem_wr_addr_o, mem_wr_data_o, e[31:16], e[15:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      alloc_v_i = 1'b0; lsu_sb_v_i = 1'b0; lsu_sb_dest_i = 3'd0;
      lsu_sb_addr_i = 16'h0000; lsu_sb_data_i = 16'h0000;
      ld_bypass_addr_i = 16'h0000; ld_bypass_sb_num_i = 3'd0;
      commit_v_i = 1'b0; mispredict_i = 1'b0; mem_wr_ready_i = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n_i = 1'b0;
      clear_inputs();
      exp_q.delete();
      tick(); tick();
      reset_n_i = 1'b1;
      tick();
   endtask

   task automatic wb(input logic [IW-1:0] dest, input logic [W-1:0] a, input logic [W-1:0] d);
      lsu_sb_v_i = 1'b1; lsu_sb_dest_i = dest; lsu_sb_addr_i = a; lsu_sb_data_i = d;
      tick();
      lsu_sb_v_i = 1'b0;
   endtask

   task automatic query(input string nm, input logic [W-1:0] a, input logic [IW-1:0] num,
                        input logic ev, input logic [W-1:0] evalue);
      ld_bypass_addr_i = a; ld_bypass_sb_num_i = num;
      #1;
      total++;
      if ({ld_bypass_valid_o, ld_bypass_value_o} !== {ev, evalue}) begin
         bad++;
         $display("FAIL %s got valid=%b value=%h exp valid=%b value=%h",
                  nm, ld_bypass_valid_o, ld_bypass_value_o, ev, evalue);
      end
   endtask

   task automatic check_count(input string nm, input logic [IW:0] ec);
      total++;
      if (sb_count_o !== ec) begin
         bad++;
         $display("FAIL %s count got=%0d exp=%0d", nm, sb_count_o, ec);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n_i = 1'b1;
      #3;
      reset_n_i = 1'b0;
      #2;
      total++;
      if ({alloc_ready_o, alloc_sb_num_o, sb_count_o, mem_wr_v_o, ld_bypass_valid_o} !== {1'b1, 3'd0, 4'd0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_ctrl got rdy=%b num=%0d cnt=%0d wv=%b bv=%b", alloc_ready_o, alloc_sb_num_o, sb_count_o, mem_wr_v_o, ld_bypass_valid_o);
      end
      total++;
      if ({mem_wr_addr_o, mem_wr_data_o, ld_bypass_value_o} !== 48'h0) begin
         bad++;
         $display("FAIL reset_data got addr=%h data=%h byp=%h exp 0", mem_wr_addr_o, mem_wr_data_o, ld_bypass_value_o);
      end
      apply_reset();
   endtask

   task automatic test_fill();
      apply_reset();
      for (int k = 0; k < N; k++) begin
         total++;
         if ({alloc_ready_o, alloc_sb_num_o} !== {1'b1, 3'(k)}) begin
            bad++;
            $display("FAIL fill_num got rdy=%b num=%0d exp rdy=1 num=%0d", alloc_ready_o, alloc_sb_num_o, k);
         end
         alloc_v_i = 1'b1;
         tick();
      end
      alloc_v_i = 1'b0;
      total++;
      if (alloc_ready_o !== 1'b0) begin
         bad++;
         $display("FAIL full_ready got=%b exp=0", alloc_ready_o);
      end
      check_count("full", 4'd8);
      alloc_v_i = 1'b1;
      tick();
      alloc_v_i = 1'b0;
      check_count("alloc_when_full", 4'd8);
      total++;
      if (alloc_sb_num_o !== 3'd0) begin
         bad++;
         $display("FAIL alloc_when_full_tail got=%0d exp=0", alloc_sb_num_o);
      end
   endtask

   // Runs on the full buffer left behind by test_fill.
   task automatic test_bypass();
      wb(3'd2, 16'h0040, 16'hBEEF);
      wb(3'd4, 16'h0040, 16'h1234);
      query("byp_sb5", 16'h0040, 3'd5, 1'b1, 16'h1234);
      query("byp_sb3", 16'h0040, 3'd3, 1'b1, 16'hBEEF);
      query("byp_sb2", 16'h0040, 3'd2, 1'b0, 16'h0000);
      query("byp_addr_miss", 16'h0041, 3'd5, 1'b0, 16'h0000);
      query("byp_empty_range", 16'h0040, 3'd0, 1'b0, 16'h0000);
      // A writeback in the same cycle must not forward yet.
      lsu_sb_v_i = 1'b1; lsu_sb_dest_i = 3'd3; lsu_sb_addr_i = 16'h0040; lsu_sb_data_i = 16'h7777;
      query("byp_same_cycle_wb", 16'h0040, 3'd4, 1'b1, 16'hBEEF);
      tick();
      lsu_sb_v_i = 1'b0;
      query("byp_after_wb", 16'h0040, 3'd4, 1'b1, 16'h7777);
   endtask

   task automatic test_drain_stall();
      apply_reset();
      alloc_v_i = 1'b1; tick(); tick(); alloc_v_i = 1'b0;
      wb(3'd0, 16'h0010, 16'hA0A0);
      wb(3'd1, 16'h0012, 16'hB1B1);
      exp_q.push_back({16'h0010, 16'hA0A0});
      commit_v_i = 1'b1; tick();
      exp_q.push_back({16'h0012, 16'hB1B1});
      tick();
      commit_v_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         total++;
         if ({mem_wr_v_o, mem_wr_addr_o, mem_wr_data_o} !== {1'b1, 16'h0010, 16'hA0A0}) begin
            bad++;
            $display("FAIL stall_hold cyc=%0d got v=%b addr=%h data=%h exp v=1 addr=0010 data=a0a0", c, mem_wr_v_o, mem_wr_addr_o, mem_wr_data_o);
         end
         check_count("stall", 4'd2);
         tick();
      end
      mem_wr_ready_i = 1'b1;
      tick();
      check_count("drain1", 4'd1);
      total++;
      if (mem_wr_addr_o !== 16'h0012) begin
         bad++;
         $display("FAIL drain_second_addr got=%h exp=0012", mem_wr_addr_o);
      end
      tick();
      check_count("drain2", 4'd0);
      total++;
      if (mem_wr_v_o !== 1'b0) begin
         bad++;
         $display("FAIL drain_done_v got=%b exp=0", mem_wr_v_o);
      end
      mem_wr_ready_i = 1'b0;
   endtask

   task automatic test_mispredict();
      apply_reset();
      alloc_v_i = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      alloc_v_i = 1'b0;
      for (int k = 0; k < 4; k++) wb(3'(k), 16'h0020 + 16'(k), 16'h5A00 + 16'(k));
      exp_q.push_back({16'h0020, 16'h5A00});
      commit_v_i = 1'b1; tick();
      // The second commit, an alloc and a writeback all land with the mispredict.
      exp_q.push_back({16'h0021, 16'h5A01});
      mispredict_i = 1'b1; alloc_v_i = 1'b1;
      lsu_sb_v_i = 1'b1; lsu_sb_dest_i = 3'd1; lsu_sb_addr_i = 16'h0099; lsu_sb_data_i = 16'h9999;
      tick();
      clear_inputs();
      check_count("mispredict", 4'd2);
      total++;
      if (alloc_sb_num_o !== 3'd2) begin
         bad++;
         $display("FAIL mispredict_tail got=%0d exp=2", alloc_sb_num_o);
      end
      mem_wr_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      mem_wr_ready_i = 1'b0;
      check_count("mispredict_drained", 4'd0);
   endtask

   task automatic test_wrap();
      int guard;
      apply_reset();
      alloc_v_i = 1'b1;
      for (int k = 0; k < N; k++) tick();
      alloc_v_i = 1'b0;
      for (int k = 0; k < N; k++) wb(3'(k), 16'h0100 + 16'(k), 16'hC000 + 16'(k));
      mem_wr_ready_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_q.push_back({16'h0100 + 16'(k), 16'hC000 + 16'(k)});
         commit_v_i = 1'b1;
         tick();
      end
      commit_v_i = 1'b0;
      guard = 0;
      while (sb_count_o != 4'd2 && guard < 20) begin
         tick();
         guard++;
      end
      mem_wr_ready_i = 1'b0;
      check_count("wrap_drained", 4'd2);
      alloc_v_i = 1'b1; tick(); alloc_v_i = 1'b0;
      total++;
      if (alloc_sb_num_o !== 3'd1) begin
         bad++;
         $display("FAIL wrap_tail got=%0d exp=1", alloc_sb_num_o);
      end
      wb(3'd0, 16'h0200, 16'hD00D);
      query("wrap_hit_idx0", 16'h0200, 3'd1, 1'b1, 16'hD00D);
      query("wrap_hit_idx7", 16'h0107, 3'd1, 1'b1, 16'hC007);
      query("wrap_hit_idx6", 16'h0106, 3'd0, 1'b1, 16'hC006);
      query("wrap_out_of_range", 16'h0200, 3'd0, 1'b0, 16'h0000);
   endtask

   task automatic test_reset_mid_drain();
      apply_reset();
      alloc_v_i = 1'b1; tick(); alloc_v_i = 1'b0;
      wb(3'd0, 16'h0300, 16'hEEEE);
      commit_v_i = 1'b1; tick(); commit_v_i = 1'b0;
      total++;
      if (mem_wr_v_o !== 1'b1) begin
         bad++;
         $display("FAIL mid_drain_pending got=%b exp=1", mem_wr_v_o);
      end
      #2;
      reset_n_i = 1'b0;
      #1;
      total++;
      if ({mem_wr_v_o, mem_wr_addr_o, mem_wr_data_o, sb_count_o, alloc_ready_o} !== {1'b0, 16'h0, 16'h0, 4'd0, 1'b1}) begin
         bad++;
         $display("FAIL async_reset got v=%b addr=%h data=%h cnt=%0d rdy=%b", mem_wr_v_o, mem_wr_addr_o, mem_wr_data_o, sb_count_o, alloc_ready_o);
      end
      exp_q.delete();
      mem_wr_ready_i = 1'b1;
      tick(); tick();
      reset_n_i = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      total++;
      if ({mem_wr_v_o, sb_count_o} !== {1'b0, 4'd0}) begin
         bad++;
         $display("FAIL post_reset got v=%b cnt=%0d exp v=0 cnt=0", mem_wr_v_o, sb_count_o);
      end
      mem_wr_ready_i = 1'b0;
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_fill();
      test_bypass();
      test_drain_stall();
      test_mispredict();
      test_wrap();
      test_reset_mid_drain();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order store buffer (memory order buffer) at the far end of the LSU store/bypass interface.
- Allocates one entry per dispatched store and accepts the resolved address and data from the LSU stage-2 writeback.
- Answers load-bypass queries combinationally in the same cycle, holds stores until ROB commit, and drains committed stores to data memory in program order.
- On mispredict, discards all uncommitted entries.

Parameters:
WORD_SIZE_P, 16, address and data width
SB_ENTRY, 8, number of entries (power of two, >=2)

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
alloc_v_i  in  1  dispatch allocates one store entry
alloc_ready_o  out  1  buffer not full; dispatch of loads and stores stalls when low
alloc_sb_num_o  out  $clog2(SB_ENTRY)  tail index; stores use it as sb_dest, loads as bypass sb_num
lsu_sb_v_i  in  1  LSU store writeback valid
lsu_sb_dest_i  in  $clog2(SB_ENTRY)  entry index being resolved
lsu_sb_addr_i  in  WORD_SIZE_P  store address
lsu_sb_data_i  in  WORD_SIZE_P  store data
ld_bypass_addr_i  in  WORD_SIZE_P  load address under query
ld_bypass_sb_num_i  in  $clog2(SB_ENTRY)  tail index captured at load dispatch
ld_bypass_valid_o  out  1  forwarding hit
ld_bypass_value_o  out  WORD_SIZE_P  forwarded data
commit_v_i  in  1  ROB retires the oldest uncommitted store
mispredict_i  in  1  flush all uncommitted entries
mem_wr_v_o  out  1  memory write request
mem_wr_addr_o  out  WORD_SIZE_P  write address
mem_wr_data_o  out  WORD_SIZE_P  write data
mem_wr_ready_i  in  1  memory accepts the write this cycle
sb_count_o  out  $clog2(SB_ENTRY)+1  occupancy

Behaviour:
- State:
  - Three pointers of $clog2(SB_ENTRY)+1 bits, each with a wrap bit: head (oldest, next to drain), cmt (first uncommitted), tail (next free).
  - Invariant: head <= cmt <= tail in age order.
  - Per entry: resolved bit, addr, data.
- Reset (async, reset_n_i low):
  - head = cmt = tail = 0; all resolved bits 0.
  - Outputs: alloc_ready_o=1, alloc_sb_num_o=0, sb_count_o=0, mem_wr_v_o=0, ld_bypass_valid_o=0, mem_wr_addr_o=0, mem_wr_data_o=0, ld_bypass_value_o=0.
  - Reset asserted mid-drain drops the pending write with no partial state.
- Derived signals:
  - sb_count_o = tail - head.
  - alloc_ready_o = (sb_count_o != SB_ENTRY), computed from registered state only; a same-cycle drain does not free a slot for a same-cycle alloc.
  - alloc_sb_num_o = tail index bits.
- Alloc: alloc_v_i && alloc_ready_o clears entry[tail].resolved and increments tail next edge. alloc_v_i while full is ignored; dispatch must not issue it.
- LSU writeback: lsu_sb_v_i writes addr and data to entry[lsu_sb_dest_i] and sets resolved.
- Commit: commit_v_i with cmt != tail increments cmt. commit_v_i with cmt == tail is ignored.
- Mispredict:
  - Next tail = cmt after any same-cycle commit; uncommitted entries are discarded.
  - A same-cycle alloc_v_i or lsu_sb_v_i is dropped.
  - Committed entries are unaffected and keep draining.
- Drain:
  - mem_wr_v_o = (head != cmt) && entry[head].resolved; addr and data come from entry[head].
  - On mem_wr_v_o && mem_wr_ready_i, head increments next edge.
  - Back-to-back drains at one entry per cycle are allowed.
  - Request stays stable while ready is low.
- Bypass (combinational, same cycle):
  - Search range is entries at age offsets 0 .. (ld_bypass_sb_num_i - head_idx - 1) mod SB_ENTRY from head. The range is empty when ld_bypass_sb_num_i == head_idx.
  - The youngest entry in range that is resolved with addr == ld_bypass_addr_i gives ld_bypass_valid_o=1 and ld_bypass_value_o = its data. Otherwise valid=0 and value=0.
  - Unresolved entries are skipped.
  - Only registered state is searched; a same-cycle lsu_sb_v_i does not forward.
  - Index arithmetic wraps modulo SB_ENTRY.
- Simultaneous alloc, writeback, commit and drain in one cycle are all legal and independent, subject to the mispredict rules above.

Test Plan:
- Reset, then alloc 8 stores -> alloc_sb_num_o steps 0..7; after the 8th, alloc_ready_o=0 and sb_count_o=8; a 9th alloc_v_i leaves tail unchanged.
- Resolve entry 2 with addr 0x0040, data 0xBEEF; resolve entry 4 with addr 0x0040, data 0x1234; query addr 0x0040 with sb_num 5 -> valid=1, value 0x1234. Query with sb_num 3 -> value 0xBEEF. Query with sb_num 2 -> valid=0.
- Commit 2 resolved entries with mem_wr_ready_i=0 for 3 cycles, then 1 -> mem_wr_v_o held with stable addr/data; two writes on consecutive cycles, in order; sb_count_o drops by 1 per cycle.
- Alloc 4, commit 1, assert mispredict together with a second commit -> tail = head+2, sb_count_o=2, only 2 entries drain.
- Fill buffer to 8, drain, and alloc across the wrap point (tail index 7->0) -> bypass query with sb_num 1 and head index 6 finds the matching entry at index 0.
- Assert reset_n_i low mid-drain, asynchronously between clock edges -> outputs return to reset values immediately; no memory write is issued after release.
